// File: rtl/eth_mac_stats.sv
// Per-frame RX/TX statistics counters with an atomically snapped shadow bank and a req/ack read port.
// Stage 1 registers the MAC strobes, stage 2 updates saturating counters; reads ack one cycle after request.
module eth_mac_stats #(
  parameter int CNT_W   = 32,
  parameter int BYTE_W  = 48,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk156,
  input  logic        rst_n,
  input  logic [29:0] rx_stat_vec,
  input  logic        rx_stat_vld,
  input  logic [25:0] tx_stat_vec,
  input  logic        tx_stat_vld,
  input  logic        snap,
  input  logic        clr,
  input  logic        rd_req,
  input  logic [3:0]  rd_addr,
  output logic        rd_ack,
  output logic [63:0] rd_data
);

  // Frame counters 0..7 are RX indices 0..7; 8..12 are TX indices 9..13.
  localparam int NF = 13;

  typedef enum logic {IDLE, ACK} rd_state_t;

  logic              s1_rx_vld, s1_tx_vld;
  logic [29:0]       s1_rx_vec;
  logic [25:0]       s1_tx_vec;
  logic [13:0]       rx_len, tx_len;
  logic [13:0]       rx_badd, tx_badd;
  logic [NF-1:0]     finc;
  logic [CNT_W-1:0]  fcnt [NF];
  logic [CNT_W-1:0]  fnext [NF];
  logic [CNT_W-1:0]  fshd [NF];
  logic [BYTE_W-1:0] rx_bcnt, tx_bcnt, rx_bnext, tx_bnext, rx_bshd, tx_bshd;
  logic [63:0]       shd_view [16];
  rd_state_t         state, state_nxt;
  logic              unused_bits;

  assign unused_bits = ^{s1_rx_vec[29:24], s1_rx_vec[9], s1_rx_vec[6:5],
                         s1_tx_vec[25:23], s1_tx_vec[8], s1_tx_vec[6:5], s1_tx_vec[2]};

  function automatic logic [BYTE_W-1:0] sat_add(input logic [BYTE_W-1:0] a, input logic [13:0] b);
    logic [BYTE_W:0] s;
    s = {1'b0, a} + (BYTE_W+1)'(b);
    return s[BYTE_W] ? '1 : s[BYTE_W-1:0];
  endfunction

  always_ff @(posedge clk156) begin
    if (!rst_n) begin
      s1_rx_vld <= 1'b0;
      s1_tx_vld <= 1'b0;
      s1_rx_vec <= '0;
      s1_tx_vec <= '0;
    end else begin
      s1_rx_vld <= rx_stat_vld;
      s1_tx_vld <= tx_stat_vld;
      s1_rx_vec <= rx_stat_vec;
      s1_tx_vec <= tx_stat_vec;
    end
  end

  always_comb begin
    rx_len  = s1_rx_vec[23:10];
    tx_len  = s1_tx_vec[22:9];
    finc    = '0;
    rx_badd = '0;
    tx_badd = '0;
    if (s1_rx_vld) begin
      finc[4:0] = s1_rx_vec[4:0];
      finc[5]   = s1_rx_vec[7];
      finc[6]   = s1_rx_vec[8];
      finc[7]   = (32'(rx_len) > MAX_LEN);
      if (s1_rx_vec[0]) rx_badd = rx_len;
    end
    if (s1_tx_vld) begin
      finc[8]  = s1_tx_vec[0];
      finc[9]  = s1_tx_vec[1];
      finc[10] = s1_tx_vec[3];
      finc[11] = s1_tx_vec[4];
      finc[12] = s1_tx_vec[7];
      if (s1_tx_vec[0]) tx_badd = tx_len;
    end
    for (int i = 0; i < NF; i++)
      fnext[i] = (&fcnt[i]) ? fcnt[i] : fcnt[i] + CNT_W'(finc[i]);
    rx_bnext = sat_add(rx_bcnt, rx_badd);
    tx_bnext = sat_add(tx_bcnt, tx_badd);
  end

  // Clear wins over the old value but not over this cycle's event; snap sees the pre-clear update.
  always_ff @(posedge clk156) begin
    if (!rst_n) begin
      for (int i = 0; i < NF; i++) begin
        fcnt[i] <= '0;
        fshd[i] <= '0;
      end
      rx_bcnt <= '0;
      tx_bcnt <= '0;
      rx_bshd <= '0;
      tx_bshd <= '0;
    end else begin
      for (int i = 0; i < NF; i++) begin
        fcnt[i] <= clr ? CNT_W'(finc[i]) : fnext[i];
        if (snap) fshd[i] <= fnext[i];
      end
      rx_bcnt <= clr ? BYTE_W'(rx_badd) : rx_bnext;
      tx_bcnt <= clr ? BYTE_W'(tx_badd) : tx_bnext;
      if (snap) begin
        rx_bshd <= rx_bnext;
        tx_bshd <= tx_bnext;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) shd_view[i] = '0;
    for (int i = 0; i < 8; i++) shd_view[i] = 64'(fshd[i]);
    shd_view[8] = 64'(rx_bshd);
    for (int i = 0; i < 5; i++) shd_view[9+i] = 64'(fshd[8+i]);
    shd_view[14] = 64'(tx_bshd);
  end

  always_ff @(posedge clk156) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && rd_req) rd_data <= shd_view[rd_addr];
    end
  end

  always_comb begin
    state_nxt = state;
    rd_ack    = 1'b0;
    case (state)
      IDLE: if (rd_req) state_nxt = ACK;
      ACK: begin
        rd_ack    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_mac_stats.sv
// Randomized and directed bench for eth_mac_stats against a frame-level counter model.
// Narrow counters (16-bit frames) keep the saturation run short.
module tb_eth_mac_stats;
  localparam int CNT_W   = 16;
  localparam int BYTE_W  = 32;
  localparam int MAX_LEN = 1518;
  localparam longint unsigned FMAX = (64'd1 << CNT_W) - 1;
  localparam longint unsigned BMAX = (64'd1 << BYTE_W) - 1;

  logic        clk156 = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] rx_stat_vec = '0;
  logic        rx_stat_vld = 1'b0;
  logic [25:0] tx_stat_vec = '0;
  logic        tx_stat_vld = 1'b0;
  logic        snap = 1'b0;
  logic        clr = 1'b0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        rd_ack;
  logic [63:0] rd_data;

  always #5 clk156 = ~clk156;

  eth_mac_stats #(.CNT_W(CNT_W), .BYTE_W(BYTE_W), .MAX_LEN(MAX_LEN)) dut (
    .clk156(clk156), .rst_n(rst_n),
    .rx_stat_vec(rx_stat_vec), .rx_stat_vld(rx_stat_vld),
    .tx_stat_vec(tx_stat_vec), .tx_stat_vld(tx_stat_vld),
    .snap(snap), .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data)
  );

  int errors = 0;
  int checks = 0;
  longint unsigned m_live [16];
  longint unsigned m_shd  [16];
  longint unsigned m_pend [16];  // increments owed by the frame seen on the previous edge

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned cmax(input int i);
    return (i == 8 || i == 14) ? BMAX : FMAX;
  endfunction

  // A frame strobed at one edge is counted at the following edge.
  function automatic void model_edge();
    longint unsigned upd [16];
    longint unsigned len;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_live[i] = 0; m_shd[i] = 0; m_pend[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 16; i++) begin
      upd[i] = m_live[i] + m_pend[i];
      if (upd[i] > cmax(i)) upd[i] = cmax(i);
    end
    for (int i = 0; i < 16; i++) begin
      if (snap) m_shd[i] = upd[i];
      m_live[i] = clr ? m_pend[i] : upd[i];
      m_pend[i] = 0;
    end
    if (rx_stat_vld) begin
      len = longint'(rx_stat_vec[23:10]);
      m_pend[0] = rx_stat_vec[0]; m_pend[1] = rx_stat_vec[1]; m_pend[2] = rx_stat_vec[2];
      m_pend[3] = rx_stat_vec[3]; m_pend[4] = rx_stat_vec[4]; m_pend[5] = rx_stat_vec[7];
      m_pend[6] = rx_stat_vec[8]; m_pend[7] = (len > MAX_LEN) ? 1 : 0;
      m_pend[8] = rx_stat_vec[0] ? len : 0;
    end
    if (tx_stat_vld) begin
      len = longint'(tx_stat_vec[22:9]);
      m_pend[9]  = tx_stat_vec[0]; m_pend[10] = tx_stat_vec[1]; m_pend[11] = tx_stat_vec[3];
      m_pend[12] = tx_stat_vec[4]; m_pend[13] = tx_stat_vec[7];
      m_pend[14] = tx_stat_vec[0] ? len : 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk156);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    rx_stat_vld = 0; tx_stat_vld = 0; snap = 0; clr = 0; rd_req = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rx_stat_vld = 0; tx_stat_vld = 0; snap = 0; clr = 0; rd_req = 0;
    rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic snap_now();
    snap = 1; tick(); snap = 0;
  endtask

  function automatic logic [29:0] rx_frame(input int len, input logic [9:0] flags);
    logic [13:0] l;
    l = 14'(len);
    return {6'b0, l, flags};
  endfunction

  function automatic logic [25:0] tx_frame(input int len, input logic [8:0] flags);
    logic [13:0] l;
    l = 14'(len);
    return {3'b0, l, flags};
  endfunction

  task automatic send_rx(input logic [29:0] v);
    rx_stat_vec = v; rx_stat_vld = 1; tick(); rx_stat_vld = 0;
  endtask

  task automatic rd_exp(input int addr, input longint unsigned exp, input string tag);
    rd_req = 1; rd_addr = 4'(addr); tick(); rd_req = 0;
    check({tag, "_ack"}, 64'(rd_ack), 64'd1);
    check(tag, rd_data, exp);
    tick();
    check({tag, "_ack_end"}, 64'(rd_ack), 64'd0);
  endtask

  task automatic rd_all_model(input string tag);
    for (int a = 0; a < 16; a++) rd_exp(a, m_shd[a], $sformatf("%s_a%0d", tag, a));
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      rx_stat_vld = 1'($urandom_range(0, 1));
      tx_stat_vld = 1'($urandom_range(0, 1));
      rx_stat_vec = 30'($urandom());
      tx_stat_vec = 26'($urandom());
      snap = ($urandom_range(0, 19) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      tick();
    end
    idle(2);
  endtask

  initial begin
    // reset state and an empty shadow bank
    idle(2);
    do_reset();
    check("rst_ack", 64'(rd_ack), 64'd0);
    check("rst_data", rd_data, 64'd0);
    for (int a = 0; a < 16; a++) rd_exp(a, 0, $sformatf("t1_a%0d", a));

    // three good frames summed into RX_GOOD/RX_BYTES, none oversize
    do_reset();
    send_rx(rx_frame(64, 10'h001));
    send_rx(rx_frame(100, 10'h001));
    send_rx(rx_frame(1518, 10'h001));
    idle(1);
    snap_now();
    rd_exp(0, 3, "t2_good");
    rd_exp(8, 1682, "t2_bytes");
    rd_exp(7, 0, "t2_oversize");

    // jumbo broadcast VLAN frame
    do_reset();
    send_rx(rx_frame(9000, 10'h089));
    idle(1);
    snap_now();
    rd_exp(0, 1, "t3_good");
    rd_exp(3, 1, "t3_bcast");
    rd_exp(5, 1, "t3_vlan");
    rd_exp(7, 1, "t3_oversize");
    rd_exp(8, 9000, "t3_bytes");
    rd_exp(1, 0, "t3_bad");

    // back-to-back RX and TX for 1000 cycles
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      rx_stat_vld = 1; tx_stat_vld = 1;
      rx_stat_vec = 30'($urandom()) | 30'h1;
      tx_stat_vec = 26'($urandom()) | 26'h1;
      tick();
    end
    idle(1);
    snap_now();
    rd_exp(0, 1000, "t4_rx_good");
    rd_exp(9, 1000, "t4_tx_good");
    rd_all_model("t4");

    // randomized traffic with random snap/clr
    do_reset();
    for (int r = 0; r < 3; r++) begin
      random_traffic(300);
      snap_now();
      rd_all_model($sformatf("rnd%0d", r));
    end

    // RX_GOOD saturation
    do_reset();
    for (int i = 0; i < int'(FMAX) - 1; i++) begin
      rx_stat_vld = 1;
      rx_stat_vec = 30'($urandom()) | 30'h1;
      tick();
    end
    idle(1);
    snap_now();
    rd_exp(0, FMAX - 1, "t5_pre");
    for (int i = 0; i < 3; i++) send_rx(rx_frame(64, 10'h001));
    idle(1);
    snap_now();
    rd_exp(0, FMAX, "t5_sat");
    rd_exp(8, m_shd[8], "t5_bytes");

    // clear coincident with a stage-2 update
    do_reset();
    send_rx(rx_frame(64, 10'h001));
    clr = 1; tick(); clr = 0;
    idle(1);
    snap_now();
    rd_exp(0, 1, "t6_clr_good");
    rd_exp(8, 64, "t6_clr_bytes");
    // snap and clear together: shadow gets pre-clear total, live restarts at the increment
    send_rx(rx_frame(100, 10'h001));
    snap = 1; clr = 1; tick(); snap = 0; clr = 0;
    rd_exp(0, 2, "t6_sc_good");
    rd_exp(8, 164, "t6_sc_bytes");
    snap_now();
    rd_exp(0, 1, "t6_live_good");
    rd_exp(8, 100, "t6_live_bytes");

    // request during ACK is ignored; snap during ACK leaves rd_data alone
    rd_req = 1; rd_addr = 4'd0; tick();
    check("ack_first", 64'(rd_ack), 64'd1);
    check("ack_first_data", rd_data, 64'd1);
    rd_addr = 4'd8; send_rx(rx_frame(64, 10'h001));
    rd_req = 0;
    check("ack_ignored", 64'(rd_ack), 64'd0);
    check("ack_hold_data", rd_data, 64'd1);
    snap = 1; tick(); snap = 0;
    rd_req = 1; rd_addr = 4'd0; tick(); rd_req = 0;
    check("ack_snap_cycle", 64'(rd_ack), 64'd1);
    snap = 1; tick(); snap = 0;
    check("ack_after_snap", 64'(rd_ack), 64'd0);
    check("data_after_snap", rd_data, 64'd2);
    tick();
    check("ack_quiet", 64'(rd_ack), 64'd0);

    // reset during ACK, and a request aborted by reset
    rd_req = 1; rd_addr = 4'd0; tick(); rd_req = 0;
    check("pre_rst_ack", 64'(rd_ack), 64'd1);
    rst_n = 0; tick(); rst_n = 1;
    check("rst_in_ack", 64'(rd_ack), 64'd0);
    check("rst_in_ack_data", rd_data, 64'd0);
    rd_req = 1; rst_n = 0; tick(); rst_n = 1; rd_req = 0;
    check("rst_abort_ack", 64'(rd_ack), 64'd0);
    tick();
    check("rst_abort_ack2", 64'(rd_ack), 64'd0);
    rd_exp(0, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
